// File: rtl/mips_sll_iter_pkg.sv
// mips_sll_iter_pkg: shared widths, level count and FSM encoding for the iterative left shifter
package mips_sll_iter_pkg;
  localparam int WORD_W = 32;
  localparam int SHAMT_W = 5;
  localparam int NUM_LEVELS = 5;
  localparam logic [2:0] LAST_STAGE = 3'(NUM_LEVELS - 1);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/mips_sll_iter_if.sv
// mips_sll_iter_if: start/busy/done request bus between the datapath and the shift unit
interface mips_sll_iter_if;
  import mips_sll_iter_pkg::*;
  logic start;
  logic [WORD_W-1:0] data_in;
  logic [SHAMT_W-1:0] shamt;
  logic busy;
  logic done;
  logic [WORD_W-1:0] result;
  modport master (output start, data_in, shamt, input busy, done, result);
  modport slave (input start, data_in, shamt, output busy, done, result);
endinterface

// File: rtl/mips_sll_iter_shl_level.sv
// mips_sll_iter_shl_level: one log-shifter level, shifts left by 1<<level when enabled
module mips_sll_iter_shl_level #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_level,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0] w_shl;
  assign w_shl = i_data << (6'd1 << i_level);
  for (genvar b = 0; b < WIDTH; b++) begin : g_mux
    assign o_data[b] = i_en ? w_shl[b] : i_data[b];
  end
endmodule

// File: rtl/mips_sll_iter.sv
// mips_sll_iter: sequential sll/sllv unit, one shifter level per clock, registered result
module mips_sll_iter
  import mips_sll_iter_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SHAMT_W_P = SHAMT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_sll_iter_if.slave bus
);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_acc, r_result, w_shifted;
  logic [SHAMT_W_P-1:0] r_amt;
  logic [2:0] r_stage;
  logic w_accept, w_last;
  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last = (r_state == S_SHIFT) && (r_stage == LAST_STAGE);
  assign bus.result = r_result;
  mips_sll_iter_shl_level #(.WIDTH(WIDTH)) u_level (
    .i_data (r_acc),
    .i_level(r_stage),
    .i_en   (r_amt[r_stage]),
    .o_data (w_shifted)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state and status outputs decoded from the current state
  always_comb begin
    w_next = w_accept ? S_SHIFT : w_last ? S_DONE : (r_state == S_DONE) ? S_IDLE : r_state;
    bus.busy = (r_state == S_SHIFT);
    bus.done = (r_state == S_DONE);
  end
  // operand capture, per-level accumulation and final result register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc <= '0;
      r_amt <= '0;
      r_stage <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_acc <= bus.data_in;
      r_amt <= bus.shamt;
      r_stage <= '0;
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_shifted;
      r_stage <= w_last ? 3'd0 : r_stage + 3'd1;
      if (w_last) r_result <= w_shifted;
    end
endmodule

// File: tb/tb_mips_sll_iter.sv
// tb_mips_sll_iter: directed and random checks of the iterative left shifter with a result scoreboard
module tb_mips_sll_iter;
  logic clk = 1'b0;
  logic rst_n;
  mips_sll_iter_if bus ();
  mips_sll_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;
  logic prev_done = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) prev_done = 1'b0;
    else begin
      if (bus.done && prev_done) chk("done_width", 32'd2, 32'd1);
      if (bus.done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("result", bus.result, exp_q.pop_front());
      end
      prev_done = bus.done;
    end
  end
  task automatic do_op(input logic [31:0] d, input logic [4:0] s, input logic [31:0] exp);
    logic [7:0] bv;
    int dc;
    bv = '0;
    dc = -1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.data_in = d; bus.shamt = s;
    exp_q.push_back(exp);
    @(negedge clk); bv[0] = bus.busy;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.data_in = $urandom; bus.shamt = 5'($urandom);
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      bv[c] = bus.busy;
      if (bus.done && dc < 0) dc = c;
      if (c == 3) chk("result_hold", bus.result, last_res);
    end
    chk("busy_pattern", 32'(bv), 32'h3E);
    chk("done_cycle", 32'(dc), 32'd6);
    last_res = exp;
  endtask
  initial begin
    logic [13:0] bv, dv;
    logic [31:0] d;
    logic [4:0] s;
    rst_n = 1'b1;
    bus.start = 1'b0; bus.data_in = '0; bus.shamt = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    do_op(32'h00000001, 5'd31, 32'h80000000);
    do_op(32'h12345678, 5'd8, 32'h34567800);
    do_op(32'hFFFFFFFF, 5'd4, 32'hFFFFFFF0);
    do_op(32'hDEADBEEF, 5'd0, 32'hDEADBEEF);
    bv = '0; dv = '0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.data_in = 32'h1; bus.shamt = 5'd1;
    exp_q.push_back(32'h00000002);
    exp_q.push_back(32'h0000001E);
    for (int c = 0; c < 14; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 2) bus.data_in = 32'hF;
      end
      @(negedge clk);
      bv[c] = bus.busy;
      dv[c] = bus.done;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("held_busy", 32'(bv), 32'h1F3E);
    chk("held_done", 32'(dv), 32'h2040);
    last_res = 32'h1E;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.data_in = 32'hA5A5A5A5; bus.shamt = 5'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", bus.result, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    last_res = '0;
    do_op(32'h00000003, 5'd2, 32'h0000000C);
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      do_op(d, s, d << s);
    end
    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
